// File: rtl/event_gen_pkg.sv
// Shared definitions for the event pulse generator: state encoding,
// counter width, minimum period and the latched burst configuration.
package event_gen_pkg;

  localparam int unsigned COUNT_W    = 32;
  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HIGH   = 2'b01,
    LOW    = 2'b10,
    FINISH = 2'b11
  } state_t;

  // Burst configuration captured on an accepted start (stored as last-phase indices)
  typedef struct packed {
    logic [COUNT_W-1:0] period_last;  // period_q - 1
    logic [COUNT_W-1:0] width_last;   // effective width - 1
    logic [COUNT_W-1:0] count;        // pulses to emit, 0 = continuous
  } cfg_t;

  // Periods below MIN_PERIOD cannot hold both a high and a low phase
  function automatic logic [COUNT_W-1:0] clamp_period(input logic [COUNT_W-1:0] p);
    return (p < COUNT_W'(MIN_PERIOD)) ? COUNT_W'(MIN_PERIOD) : p;
  endfunction

endpackage

// File: rtl/event_pulse_generator_period_timer.sv
// period_timer: per-period phase counter for the pulse generator.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   clear           - reload phase_cnt to 0 (start of a period)
//   enable          - advance phase_cnt by one
//   period_last     - phase index of the last cycle of the period
//   width_last      - phase index of the last high cycle
//   terminal        - phase_cnt == period_last
//   mark_hit_c      - phase_cnt == width_last
module period_timer
  import event_gen_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [COUNT_W-1:0] period_last,
  input  logic [COUNT_W-1:0] width_last,
  output logic               terminal,
  output logic               mark_hit_c
);

  logic [COUNT_W-1:0] phase_cnt;

  // Phase counter, restarted at every pulse rise
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt <= '0;
    end else if (clear) begin
      phase_cnt <= '0;
    end else if (enable) begin
      phase_cnt <= phase_cnt + COUNT_W'(1);
    end
  end

  assign terminal   = (phase_cnt == period_last);
  assign mark_hit_c = (phase_cnt == width_last);

endmodule

// File: rtl/event_pulse_generator.sv
// event_pulse_generator: programmable pulse source for the event counter.
// Emits pulses of PULSE_WIDTH cycles every `period` cycles, for
// `pulse_count` pulses or continuously when pulse_count is 0.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   period         - pulse period in cycles (latched on accepted start)
//   pulse_count    - pulses per burst, 0 = continuous (latched on start)
//   start, stop    - start level (IDLE only), abort request (any state)
//   event_trigger  - pulse output
//   busy           - high while emitting (HIGH/LOW)
//   done           - one-cycle strobe at the end of a finite burst
//   pulses_sent    - pulses emitted since the last accepted start
module event_pulse_generator
  import event_gen_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned PULSE_WIDTH     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] period,
  input  logic [COUNT_W-1:0] pulse_count,
  input  logic               start,
  input  logic               stop,
  output logic               event_trigger,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] pulses_sent
);

  if (PULSE_WIDTH < 1 || PULSE_WIDTH > 255 || CLOCK_FREQUENCY == 0) begin : g_param_check
    $error("event_pulse_generator: PULSE_WIDTH or CLOCK_FREQUENCY out of range");
  end

  state_t             state;
  state_t             state_next;
  cfg_t               cfg_q;
  logic               accept_c;
  logic               timer_clear_c;
  logic               timer_en_c;
  logic               terminal;
  logic               mark_hit_c;
  logic [COUNT_W-1:0] period_eff_c;
  logic [COUNT_W-1:0] width_eff_c;

  // Effective period/width from the live inputs, used only when a start is accepted
  assign period_eff_c = clamp_period(period);
  assign width_eff_c  = (COUNT_W'(PULSE_WIDTH) < period_eff_c - COUNT_W'(1))
                      ? COUNT_W'(PULSE_WIDTH) : period_eff_c - COUNT_W'(1);

  period_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (timer_clear_c),
    .enable      (timer_en_c),
    .period_last (cfg_q.period_last),
    .width_last  (cfg_q.width_last),
    .terminal    (terminal),
    .mark_hit_c  (mark_hit_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and timer control
  always_comb begin
    state_next    = state;
    accept_c      = 1'b0;
    timer_clear_c = 1'b0;
    timer_en_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          accept_c      = 1'b1;
          timer_clear_c = 1'b1;
          state_next    = HIGH;
        end
      end
      HIGH: begin
        timer_en_c = 1'b1;
        if (stop) begin
          state_next = IDLE;
        end else if (mark_hit_c) begin
          state_next = LOW;
        end
      end
      LOW: begin
        timer_en_c = 1'b1;
        if (stop) begin
          state_next = IDLE;
        end else if (terminal) begin
          if (cfg_q.count != '0 && pulses_sent == cfg_q.count) begin
            state_next = FINISH;
          end else begin
            timer_clear_c = 1'b1;
            state_next    = HIGH;
          end
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Configuration latch and registered outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q         <= '0;
      event_trigger <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pulses_sent   <= '0;
    end else begin
      if (accept_c) begin
        cfg_q.period_last <= period_eff_c - COUNT_W'(1);
        cfg_q.width_last  <= width_eff_c - COUNT_W'(1);
        cfg_q.count       <= pulse_count;
      end
      event_trigger <= (state_next == HIGH);
      busy          <= (state_next == HIGH) || (state_next == LOW);
      done          <= (state_next == FINISH);
      // Counter moves together with the rising pulse; wraps in continuous mode
      if (accept_c) begin
        pulses_sent <= COUNT_W'(1);
      end else if (state == LOW && state_next == HIGH) begin
        pulses_sent <= pulses_sent + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_event_pulse_generator.sv
// Scoreboard bench for event_pulse_generator: expected per-cycle outputs are
// queued when a burst is launched and popped/compared every cycle.
module tb_event_pulse_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] period = '0;
  logic [31:0] pulse_count = '0;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        stop = 1'b0;

  logic        trig, busy, done;
  logic [31:0] ps;
  logic        trig4, busy4, done4;
  logic [31:0] ps4;

  always #5 clk = ~clk;

  event_pulse_generator #(.CLOCK_FREQUENCY(100_000_000), .PULSE_WIDTH(1)) dut (
    .clk(clk), .reset(reset), .period(period), .pulse_count(pulse_count),
    .start(start), .stop(stop),
    .event_trigger(trig), .busy(busy), .done(done), .pulses_sent(ps)
  );

  event_pulse_generator #(.CLOCK_FREQUENCY(100_000_000), .PULSE_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .period(period), .pulse_count(pulse_count),
    .start(start4), .stop(stop),
    .event_trigger(trig4), .busy(busy4), .done(done4), .pulses_sent(ps4)
  );

  typedef struct packed {
    logic        trig;
    logic        busy;
    logic        done;
    logic [31:0] ps;
  } obs_t;

  obs_t sb[$];
  obs_t act;
  obs_t exp_v;
  int   tests = 0;
  int   fails = 0;

  function automatic longint peff(input logic [31:0] p);
    return (p < 32'd2) ? 64'd2 : longint'(p);
  endfunction

  function automatic longint weff(input longint pw, input longint pe);
    return (pw < pe - 1) ? pw : pe - 1;
  endfunction

  // Expected outputs t cycles after the accepting edge
  function automatic obs_t model(input longint p, input longint w, input longint n, input longint t);
    obs_t o;
    o = '0;
    if (n == 0 || t <= n * p) begin
      o.trig = (((t - 1) % p) < w);
      o.busy = 1'b1;
      o.ps   = 32'((t - 1) / p + 1);
    end else if (t == n * p + 1) begin
      o.done = 1'b1;
      o.ps   = 32'(n);
    end else begin
      o.ps   = 32'(n);
    end
    return o;
  endfunction

  task automatic push_burst(input longint p, input longint w, input longint n,
                            input longint t0, input int cycles);
    for (int i = 0; i < cycles; i++) sb.push_back(model(p, w, n, t0 + i));
  endtask

  task automatic push_idle(input logic [31:0] hold_ps, input int cycles);
    obs_t o;
    o = '0;
    o.ps = hold_ps;
    for (int i = 0; i < cycles; i++) sb.push_back(o);
  endtask

  task automatic test_reset();
    push_idle(32'd0, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b0;
      exp_v = sb.pop_front();
      act = {trig, busy, done, ps};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL reset cyc%0d got %h want %h", i, act, exp_v);
      end
      act = {trig4, busy4, done4, ps4};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL reset_w4 cyc%0d got %h want %h", i, act, exp_v);
      end
    end
  endtask

  task automatic test_finite();
    @(negedge clk);
    period = 32'd10; pulse_count = 32'd3; start = 1'b1;
    push_burst(10, 1, 3, 1, 36);
    for (int t = 1; t <= 36; t++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      act = {trig, busy, done, ps};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL finite t=%0d got %h want %h", t, act, exp_v);
      end
    end
  endtask

  task automatic test_clamp();
    @(negedge clk);
    period = 32'd3; pulse_count = 32'd2; start4 = 1'b1;
    push_burst(peff(32'd3), weff(4, peff(32'd3)), 2, 1, 9);
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      start4 = 1'b0;
      exp_v = sb.pop_front();
      act = {trig4, busy4, done4, ps4};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL clamp_width t=%0d got %h want %h", t, act, exp_v);
      end
    end
    @(negedge clk);
    period = 32'd0; pulse_count = 32'd3; start = 1'b1;
    push_burst(peff(32'd0), weff(1, peff(32'd0)), 3, 1, 9);
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      act = {trig, busy, done, ps};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL clamp_period t=%0d got %h want %h", t, act, exp_v);
      end
    end
  endtask

  task automatic test_stop_continuous();
    @(negedge clk);
    period = 32'd5; pulse_count = 32'd0; start = 1'b1;
    push_burst(5, 1, 0, 1, 31);
    push_idle(32'd7, 6);
    for (int t = 1; t <= 37; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 32) stop = 1'b0;
      exp_v = sb.pop_front();
      act = {trig, busy, done, ps};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL stop_cont t=%0d got %h want %h", t, act, exp_v);
      end
      // pulse 7 is high at t=31: abort there
      if (t == 31) stop = 1'b1;
    end
  endtask

  task automatic test_start_stop_together();
    @(negedge clk);
    period = 32'd4; pulse_count = 32'd2; start = 1'b1; stop = 1'b1;
    push_idle(32'd7, 5);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      exp_v = sb.pop_front();
      act = {trig, busy, done, ps};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL start_stop t=%0d got %h want %h", t, act, exp_v);
      end
    end
  endtask

  task automatic test_start_mid_burst();
    @(negedge clk);
    period = 32'd6; pulse_count = 32'd3; start = 1'b1;
    push_burst(6, 1, 3, 1, 22);
    for (int t = 1; t <= 22; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      if (t == 8) begin
        start = 1'b1; period = 32'd2; pulse_count = 32'd9;
      end
      if (t == 12) start = 1'b0;
      exp_v = sb.pop_front();
      act = {trig, busy, done, ps};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL mid_start t=%0d got %h want %h", t, act, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_low();
    @(negedge clk);
    period = 32'd10; pulse_count = 32'd3; start = 1'b1;
    push_burst(10, 1, 3, 1, 5);
    push_idle(32'd0, 1);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 6) reset = 1'b0;
      exp_v = sb.pop_front();
      act = {trig, busy, done, ps};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL reset_low t=%0d got %h want %h", t, act, exp_v);
      end
      if (t == 5) reset = 1'b1;
    end
    @(negedge clk);
    period = 32'd4; pulse_count = 32'd2; start = 1'b1;
    push_burst(4, 1, 2, 1, 10);
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      act = {trig, busy, done, ps};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL post_reset t=%0d got %h want %h", t, act, exp_v);
      end
    end
  endtask

  task automatic test_rearm();
    @(negedge clk);
    period = 32'd3; pulse_count = 32'd1; start = 1'b1;
    // FINISH at t=4, IDLE at t=5 accepts, next burst rises at t=6
    push_burst(3, 1, 1, 1, 5);
    push_burst(3, 1, 1, 1, 2);
    push_idle(32'd1, 2);
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      if (t == 8) stop = 1'b0;
      exp_v = sb.pop_front();
      act = {trig, busy, done, ps};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL rearm t=%0d got %h want %h", t, act, exp_v);
      end
      if (t == 7) begin
        start = 1'b0; stop = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_finite();
    test_clamp();
    test_stop_continuous();
    test_start_stop_together();
    test_start_mid_burst();
    test_reset_mid_low();
    test_rearm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_pulse_generator.md
# event_pulse_generator

Programmable pulse source that drives the `event_trigger` input of the synchronous event counter. It emits single-clock-domain pulses at a programmed period, either for a programmed number of pulses or continuously. It is the stimulus end of the event-count interface: on-board self-test of the period-counter path, and a bench source for counter verification. The block sits beside the counter and is configured by the MicroBlaze through GPIO or register outputs.

## Interface
Parameters:
- `CLOCK_FREQUENCY`, default 100_000_000: clock rate in Hz; documentation only, no logic depends on it.
- `PULSE_WIDTH`, default 1: high time of each pulse in clock cycles, range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `period`, in, 32: pulse period in clock cycles. Sampled only on an accepted start.
- `pulse_count`, in, 32: number of pulses to emit; 0 means continuous. Sampled only on an accepted start.
- `start`, in, 1: level, sampled each cycle; accepted only in IDLE.
- `stop`, in, 1: abort request; honoured in any state.
- `event_trigger`, out, 1, reg: pulse output to the counter.
- `busy`, out, 1, reg: generator is running.
- `done`, out, 1, reg: one-cycle strobe when a finite burst completes normally.
- `pulses_sent`, out, 32, reg: pulses emitted since the last accepted start.

## Operation
- States, 2-bit binary: IDLE=00, HIGH=01, LOW=10, FINISH=11.
- **IDLE**
  - On `start`=1 and `stop`=0, latch `period_q` and `count_q`.
  - Clamp `period_q` to a minimum of 2.
  - Effective width = min(`PULSE_WIDTH`, `period_q`−1).
  - Clear `pulses_sent`, then go to HIGH.
- **HIGH**
  - `event_trigger`=1 for the effective width.
  - On entry, `pulses_sent` increments; the new value and `event_trigger` rise in the same cycle.
  - Then go to LOW.
- **LOW**
  - `event_trigger`=0 for `period_q` − width cycles.
  - At the end of the low phase, go to FINISH if `count_q`≠0 and `pulses_sent`==`count_q`; otherwise go to HIGH.
- **FINISH**
  - `done`=1 and `busy`=0 for this one cycle.
  - Go to IDLE.
- A single 32-bit cycle counter `phase_cnt` runs from 0 to `period_q`−1 within each period and resets to 0 on each HIGH entry.
- `busy`=1 in HIGH and LOW only.
- Continuous mode: `pulses_sent` wraps from 0xFFFFFFFF to 0 and the generator keeps running.
- `stop` in HIGH, LOW or FINISH:
  - Next cycle: state=IDLE, `event_trigger`=0, `busy`=0, `done`=0.
  - `pulses_sent` holds its value.
- `start` and `stop` both high in IDLE: stop wins and nothing starts.
- `start` while busy is ignored. Changes to `period` or `pulse_count` while busy have no effect.
- `start` held high through FINISH re-arms. A new burst is accepted in the IDLE cycle that follows FINISH.
- `reset` overrides everything:
  - Next cycle: IDLE, and every output is 0.
  - Internal registers are cleared.
  - Power-up register values are the same.

## Timing
- `start` sampled high at edge T: `event_trigger` is high from T+1 to T+width. Pulse k (k=0..N−1) rises at T+1+k·`period_q`.
- Finite burst of N pulses:
  - `done` is high for exactly cycle T+1+N·`period_q`, with `busy` low in that cycle.
  - `busy` is high from T+1 through T+N·`period_q`.
- `stop` sampled at edge S: all outputs are idle at S+1, so there is a one-cycle latency.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `event_gen_pkg`:
  - state encoding constants IDLE/HIGH/LOW/FINISH;
  - `MIN_PERIOD`=2;
  - `COUNT_W`=32.
- One sub-module, `period_timer`:
  - loadable 32-bit up-counter with `clear`, `enable` and a `terminal` flag (`phase_cnt`==`period_q`−1);
  - reused for the high/low boundary compare.
- The FSM and output registers live in `event_pulse_generator`.

## Test plan
- `period`=10, `pulse_count`=3, `PULSE_WIDTH`=1, `start` at T:
  - `event_trigger` high at T+1, T+11, T+21;
  - `done` at T+31;
  - `pulses_sent`=3;
  - `busy` low from T+31.
- `PULSE_WIDTH`=4, `period`=3: width clamps to 2, so high 2 cycles and low 1. `period`=0 clamps to 2, so pulses 2 cycles apart.
- Continuous, `period`=5, `stop` at pulse 7's high phase:
  - `event_trigger` and `busy` are 0 the next cycle;
  - `pulses_sent`=7;
  - `done` never asserts.
- `start` and `stop` high together in IDLE: no pulse, `busy` stays 0. `start` mid-burst: pulse spacing is unchanged.
- `reset` asserted mid-LOW: next cycle all outputs are 0. `start` after reset release runs a clean burst.
- Closed loop with the event counter overridden to a 1000-cycle gate, generator continuous at `period`=10: each report gives `events_counted`=100 ±1.
